vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 800x525 sync block.
- Produces programmable-geometry counters, sync pulses with selectable polarity, data-enable, and frame/line strobes.
- Provides a configurable latency-compensation pipeline, so a downstream pixel source (text overlay, page renderer) can take PIPE_DLY cycles without sync/colour skew.
- Sits between the pixel clock and the DAC/VGA pins; drawing logic hangs off o_x/o_y and returns colour on i_R/i_G/i_B.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 47 ++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants, types and helpers for the VGA raster timing generator.
package vga_timing_pkg;

   // 640x480@60 geometry, the default build
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Reduced geometry (15 x 7) so a whole frame fits in a short simulation
   localparam int SIM_H_ACTIVE = 8;
   localparam int SIM_H_FP     = 2;
   localparam int SIM_H_SYNC   = 3;
   localparam int SIM_H_BP     = 2;
   localparam int SIM_V_ACTIVE = 4;
   localparam int SIM_V_FP     = 1;
   localparam int SIM_V_SYNC   = 1;
   localparam int SIM_V_BP     = 1;

   // Timing word carried down the latency pipeline. Fields mean "asserted";
   // sync polarity is applied only at the pins.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_word_t;

   localparam sync_word_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

   // Length of a line or frame from its four regions
   function automatic int total(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset and synchronous flush.
// DEPTH=0 degenerates to a wire (flush still forces the idle value).
module vga_delay_line #(
   parameter int                WIDTH   = 3,
   parameter int                DEPTH   = 2,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [WIDTH-1:0]  d,
   output logic [WIDTH-1:0]  q
);

   if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = clk ^ rst;
      assign q = flush ? RST_VAL : d;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      // Next-state of every stage: shift by one, or load idle on flush
      always_comb begin
         stage_d[0] = flush ? RST_VAL : d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = flush ? RST_VAL : stage_q[i-1];
         end
      end

      // Stage registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= RST_VAL;
            end
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= stage_d[i];
            end
         end
      end

      assign q = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a latency-compensation
// pipeline so a pixel source taking PIPE_DLY cycles stays aligned with sync.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   COLOR_W   = 8,
   parameter int   PIPE_DLY  = 2,
   localparam int  H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int  V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int  HW        = $clog2(H_TOTAL),
   localparam int  VW        = $clog2(V_TOTAL)
) (
   input  logic               VGA_CLK_IN,
   input  logic               VGA_RST_IN,
   input  logic               i_en,
   input  logic [COLOR_W-1:0] i_R,
   input  logic [COLOR_W-1:0] i_G,
   input  logic [COLOR_W-1:0] i_B,
   output logic               VGA_CLK_OUT,
   output logic [HW-1:0]      o_x,
   output logic [VW-1:0]      o_y,
   output logic               o_active,
   output logic               o_frame_start,
   output logic               o_line_start,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic [COLOR_W-1:0] out_R,
   output logic [COLOR_W-1:0] out_G,
   output logic [COLOR_W-1:0] out_B
);

   if (PIPE_DLY < 0 || PIPE_DLY > 4 || H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 ||
       H_BP <= 0 || V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_param_check
      $error("vga_timing_gen: PIPE_DLY must be 0..4 and every timing parameter non-zero");
   end

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic               running_q, running_d;
   logic [HW-1:0]      h_q, h_d;
   logic [VW-1:0]      v_q, v_d;
   sync_word_t         raw_word;
   sync_word_t         dly_word;
   sync_word_t         out_word_q, out_word_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   // Raster position: any edge with i_en low parks at (0,0) so a restart
   // always begins a fresh frame; the first enabled edge only arms running.
   always_comb begin
      running_d = running_q;
      h_d       = h_q;
      v_d       = v_q;
      if (!i_en) begin
         running_d = 1'b0;
         h_d       = '0;
         v_d       = '0;
      end else if (!running_q) begin
         running_d = 1'b1;
         h_d       = '0;
         v_d       = '0;
      end else if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
      end
   end

   // Counter and run-state registers
   always_ff @(posedge VGA_CLK_IN or posedge VGA_RST_IN) begin
      if (VGA_RST_IN) begin
         running_q <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
      end else begin
         running_q <= running_d;
         h_q       <= h_d;
         v_q       <= v_d;
      end
   end

   // Stage-0 timing word decoded straight from the counters
   always_comb begin
      raw_word = SYNC_IDLE;
      if (running_q) begin
         raw_word.hs = (h_q >= HS_START) && (h_q < HS_END);
         raw_word.vs = (v_q >= VS_START) && (v_q < VS_END);
         raw_word.de = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      end
   end

   vga_delay_line #(
      .WIDTH   ($bits(sync_word_t)),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (SYNC_IDLE)
   ) u_delay (
      .clk   (VGA_CLK_IN),
      .rst   (VGA_RST_IN),
      .flush (~i_en),
      .d     (raw_word),
      .q     (dly_word)
   );

   // Output stage: pair the delayed timing word with the colour that the
   // pixel source returns for that same position, blanking outside de.
   always_comb begin
      out_word_d = SYNC_IDLE;
      r_d        = '0;
      g_d        = '0;
      b_d        = '0;
      if (i_en) begin
         out_word_d = dly_word;
         if (dly_word.de) begin
            r_d = i_R;
            g_d = i_G;
            b_d = i_B;
         end
      end
   end

   // Output registers
   always_ff @(posedge VGA_CLK_IN or posedge VGA_RST_IN) begin
      if (VGA_RST_IN) begin
         out_word_q <= SYNC_IDLE;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
      end else begin
         out_word_q <= out_word_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
      end
   end

   assign VGA_CLK_OUT   = VGA_CLK_IN;
   assign o_x           = h_q;
   assign o_y           = v_q;
   assign o_active      = running_q && (h_q < H_ACT_END) && (v_q < V_ACT_END);
   assign o_line_start  = running_q && (h_q == '0);
   assign o_frame_start = running_q && (h_q == '0) && (v_q == '0);
   assign o_hsync       = out_word_q.hs ? HSYNC_POL : ~HSYNC_POL;
   assign o_vsync       = out_word_q.vs ? VSYNC_POL : ~VSYNC_POL;
   assign o_de          = out_word_q.de;
   assign out_R         = r_q;
   assign out_G         = g_q;
   assign out_B         = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three builds (PIPE_DLY 2, 0, 4) of the reduced geometry
// driven together and compared against a position/time model of the raster.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int HA   = SIM_H_ACTIVE;
   localparam int HFP  = SIM_H_FP;
   localparam int HSY  = SIM_H_SYNC;
   localparam int HBP  = SIM_H_BP;
   localparam int VA   = SIM_V_ACTIVE;
   localparam int VFP  = SIM_V_FP;
   localparam int VSY  = SIM_V_SYNC;
   localparam int VBP  = SIM_V_BP;
   localparam int HT   = HA + HFP + HSY + HBP;
   localparam int VT   = VA + VFP + VSY + VBP;
   localparam int XW   = $clog2(HT);
   localparam int YW   = $clog2(VT);
   localparam int CW   = 8;
   localparam int MAXC = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_en = 1'b0;
   logic [CW-1:0] i_R = '0, i_G = '0, i_B = '0;

   logic          d2_clk, d2_act, d2_fs, d2_ls, d2_hs, d2_vs, d2_de;
   logic [XW-1:0] d2_x;
   logic [YW-1:0] d2_y;
   logic [CW-1:0] d2_r, d2_g, d2_b;
   logic          d0_clk, d0_act, d0_fs, d0_ls, d0_hs, d0_vs, d0_de;
   logic [XW-1:0] d0_x;
   logic [YW-1:0] d0_y;
   logic [CW-1:0] d0_r, d0_g, d0_b;
   logic          d4_clk, d4_act, d4_fs, d4_ls, d4_hs, d4_vs, d4_de;
   logic [XW-1:0] d4_x;
   logic [YW-1:0] d4_y;
   logic [CW-1:0] d4_r, d4_g, d4_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: whether the raster runs and how many cycles it has run
   bit m_run = 1'b0;
   int m_n   = 0;

   // Per-cycle history seen by the model
   bit en_hist [MAXC];
   bit raw_hs  [MAXC];
   bit raw_vs  [MAXC];
   bit raw_de  [MAXC];
   int x_hist  [MAXC];
   int g_hist  [MAXC];
   int b_hist  [MAXC];
   bit hs_log  [MAXC];
   bit vs_log  [MAXC];
   bit de_log  [MAXC];
   bit fs_log  [MAXC];
   bit de0_log [MAXC];
   bit de4_log [MAXC];

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(CW), .PIPE_DLY(2)) dut (
      .VGA_CLK_IN(clk), .VGA_RST_IN(rst), .i_en(i_en), .i_R(i_R), .i_G(i_G), .i_B(i_B),
      .VGA_CLK_OUT(d2_clk), .o_x(d2_x), .o_y(d2_y), .o_active(d2_act),
      .o_frame_start(d2_fs), .o_line_start(d2_ls), .o_hsync(d2_hs), .o_vsync(d2_vs),
      .o_de(d2_de), .out_R(d2_r), .out_G(d2_g), .out_B(d2_b));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(CW), .PIPE_DLY(0)) dut_d0 (
      .VGA_CLK_IN(clk), .VGA_RST_IN(rst), .i_en(i_en), .i_R(i_R), .i_G(i_G), .i_B(i_B),
      .VGA_CLK_OUT(d0_clk), .o_x(d0_x), .o_y(d0_y), .o_active(d0_act),
      .o_frame_start(d0_fs), .o_line_start(d0_ls), .o_hsync(d0_hs), .o_vsync(d0_vs),
      .o_de(d0_de), .out_R(d0_r), .out_G(d0_g), .out_B(d0_b));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(CW), .PIPE_DLY(4)) dut_d4 (
      .VGA_CLK_IN(clk), .VGA_RST_IN(rst), .i_en(i_en), .i_R(i_R), .i_G(i_G), .i_B(i_B),
      .VGA_CLK_OUT(d4_clk), .o_x(d4_x), .o_y(d4_y), .o_active(d4_act),
      .o_frame_start(d4_fs), .o_line_start(d4_ls), .o_hsync(d4_hs), .o_vsync(d4_vs),
      .o_de(d4_de), .out_R(d4_r), .out_G(d4_g), .out_B(d4_b));

   // Pixel clock
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check, reports each mismatch
   task automatic checkOutput(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Expected asserted {hs,vs,de} at cycle t for a build with latency d:
   // the word decoded d+1 cycles ago, provided no flush/reset edge intervened.
   function automatic logic [2:0] expWord(input int t, input int d);
      if (t - d - 1 < 0) return 3'b000;
      for (int k = t - d - 1; k < t; k++) begin
         if (!en_hist[k]) return 3'b000;
      end
      return {raw_hs[t-d-1], raw_vs[t-d-1], raw_de[t-d-1]};
   endfunction

   // Compare one build's aligned outputs against the model
   task automatic checkPipe(input string name, input int d, input logic hs, input logic vs,
                            input logic de, input logic [CW-1:0] g, input logic [CW-1:0] b);
      logic [2:0] w;
      w = expWord(cyc, d);
      checkOutput({name, "_hsync"}, hs, w[2] ? 0 : 1);
      checkOutput({name, "_vsync"}, vs, w[1] ? 0 : 1);
      checkOutput({name, "_de"},    de, w[0]);
      checkOutput({name, "_G"},     g,  (w[0] && cyc >= 1) ? g_hist[cyc-1] : 0);
      checkOutput({name, "_B"},     b,  (w[0] && cyc >= 1) ? b_hist[cyc-1] : 0);
   endtask

   // Full per-cycle comparison, sampled on the falling edge
   task automatic checkCycle();
      int         ex, ey;
      logic [2:0] w2;
      ex = m_run ? (m_n % HT) : 0;
      ey = m_run ? ((m_n / HT) % VT) : 0;
      checkOutput("x",           d2_x,   ex);
      checkOutput("y",           d2_y,   ey);
      checkOutput("active",      d2_act, (m_run && ex < HA && ey < VA) ? 1 : 0);
      checkOutput("frame_start", d2_fs,  (m_run && ex == 0 && ey == 0) ? 1 : 0);
      checkOutput("line_start",  d2_ls,  (m_run && ex == 0) ? 1 : 0);
      checkOutput("clk_out",     d2_clk, 0);
      checkOutput("d0_x",        d0_x,   ex);
      checkOutput("d4_y",        d4_y,   ey);
      checkPipe("d2", 2, d2_hs, d2_vs, d2_de, d2_g, d2_b);
      checkPipe("d0", 0, d0_hs, d0_vs, d0_de, d0_g, d0_b);
      checkPipe("d4", 4, d4_hs, d4_vs, d4_de, d4_g, d4_b);
      w2 = expWord(cyc, 2);
      checkOutput("d2_R_is_x", d2_r, (w2[0] && cyc >= 3) ? x_hist[cyc-3] : 0);
      hs_log[cyc]  = d2_hs;
      vs_log[cyc]  = d2_vs;
      de_log[cyc]  = d2_de;
      fs_log[cyc]  = d2_fs;
      de0_log[cyc] = d0_de;
      de4_log[cyc] = d4_de;
   endtask

   // One clock: drive inputs (pixel source returns x of the position issued
   // two cycles ago), advance the model across the edge, then check.
   task automatic applyStimulus(input bit en);
      int px, py;
      bit eff;
      if (cyc >= MAXC - 1) begin
         $display("[TB] FAIL history: cycle index %0d, expected below %0d", cyc, MAXC - 1);
         $fatal(1, "[TB] history overflow");
      end
      px = m_run ? (m_n % HT) : 0;
      py = m_run ? ((m_n / HT) % VT) : 0;
      x_hist[cyc] = px;
      raw_hs[cyc] = m_run && px >= HA + HFP && px < HA + HFP + HSY;
      raw_vs[cyc] = m_run && py >= VA + VFP && py < VA + VFP + VSY;
      raw_de[cyc] = m_run && px < HA && py < VA;
      i_en = en;
      i_R  = (cyc >= 2) ? CW'(x_hist[cyc-2]) : '0;
      i_G  = CW'($urandom);
      i_B  = CW'($urandom);
      g_hist[cyc] = int'(i_G);
      b_hist[cyc] = int'(i_B);
      @(posedge clk);
      eff = en && !rst;
      en_hist[cyc] = eff;
      if (!eff) begin
         m_run = 1'b0;
         m_n   = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_n   = 0;
      end else begin
         m_n++;
      end
      cyc++;
      @(negedge clk);
      checkCycle();
   endtask

   // Stimulus sequence
   initial begin
      int  c1, t0, gap, cnt, first;
      bit  hit;

      // Reset values straight after an asynchronous reset
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_x",      d2_x,  0);
      checkOutput("rst_y",      d2_y,  0);
      checkOutput("rst_hsync",  d2_hs, 1);
      checkOutput("rst_vsync",  d2_vs, 1);
      checkOutput("rst_de",     d2_de, 0);
      checkOutput("rst_R",      d2_r,  0);
      checkOutput("rst_fs",     d2_fs, 0);
      checkOutput("rst_active", d2_act, 0);
      @(negedge clk);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      rst = 1'b0;

      // First running cycle presents (0,0) with the frame strobe
      applyStimulus(1'b1);
      checkOutput("first_fs", d2_fs, 1);
      c1 = cyc;
      for (int i = 0; i < 250; i++) applyStimulus(1'b1);

      // Frame period
      gap = -1;
      for (int k = c1 + 1; k < c1 + 300 && gap < 0; k++) begin
         if (fs_log[k]) gap = k - c1;
      end
      checkOutput("fs_period", gap, HT * VT);

      // Sync and data-enable counts over one steady-state frame / line
      t0  = c1 + HT * VT;
      cnt = 0;
      for (int k = t0; k < t0 + HT * VT; k++) if (!vs_log[k]) cnt++;
      checkOutput("vsync_low_per_frame", cnt, VSY * HT);
      cnt = 0;
      for (int k = t0; k < t0 + HT * VT; k++) if (de_log[k]) cnt++;
      checkOutput("de_per_frame", cnt, HA * VA);
      cnt = 0;
      for (int k = t0; k < t0 + HT; k++) if (!hs_log[k]) cnt++;
      checkOutput("hsync_low_per_line", cnt, HSY);
      first = -1;
      for (int k = 1; k <= HT && first < 0; k++) begin
         if (hs_log[t0+k-1] && !hs_log[t0+k]) first = k;
      end
      checkOutput("hsync_fall_offset", first, HA + HFP + 3);

      // o_de rise after line start for the shallow and deep builds
      first = -1;
      for (int k = 0; k < 9 && first < 0; k++) if (de0_log[t0+k]) first = k;
      checkOutput("d0_de_rise", first, 1);
      first = -1;
      for (int k = 0; k < 9 && first < 0; k++) if (de4_log[t0+k]) first = k;
      checkOutput("d4_de_rise", first, 5);

      // Randomised enable drops
      for (int i = 0; i < 600; i++) applyStimulus($urandom_range(0, 99) >= 3);

      // Enable dropped at (5,2), then restarted
      applyStimulus(1'b1);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_run && (m_n % HT) == 5 && ((m_n / HT) % VT) == 2) hit = 1'b1;
         else applyStimulus(1'b1);
      end
      checkOutput("reach_5_2", hit, 1);
      applyStimulus(1'b0);
      checkOutput("drop_de",    d2_de, 0);
      checkOutput("drop_R",     d2_r,  0);
      checkOutput("drop_G",     d2_g,  0);
      checkOutput("drop_hsync", d2_hs, 1);
      checkOutput("drop_vsync", d2_vs, 1);
      checkOutput("drop_x",     d2_x,  0);
      checkOutput("drop_y",     d2_y,  0);
      applyStimulus(1'b1);
      checkOutput("restart_fs", d2_fs, 1);

      // Asynchronous reset mid-line while colour is flowing
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_run && (m_n % HT) == 6 && ((m_n / HT) % VT) == 1) hit = 1'b1;
         else applyStimulus(1'b1);
      end
      checkOutput("reach_6_1", hit, 1);
      checkOutput("pre_arst_de", d2_de, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_x",      d2_x,   0);
      checkOutput("arst_y",      d2_y,   0);
      checkOutput("arst_de",     d2_de,  0);
      checkOutput("arst_R",      d2_r,   0);
      checkOutput("arst_hsync",  d2_hs,  1);
      checkOutput("arst_active", d2_act, 0);
      checkOutput("arst_ls",     d2_ls,  0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) applyStimulus(1'b1);

      $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
